// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: widths, opcode encodings,
// instruction field positions and the sequencer state encoding.
package fetch_sequencer_pkg;

  localparam int PC_W      = 7;
  localparam int INSTR_W   = 20;
  localparam int LAST_ADDR = 45;
  localparam int CNT_W     = 16;

  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 16;
  localparam int TGT_MSB = 15;
  localparam int TGT_LSB = 10;
  localparam int TGT_W   = TGT_MSB - TGT_LSB + 1;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(LAST_ADDR);

  // Only JMP/JMPZ/END steer fetch; the rest are listed for the decode stage.
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_LD   = 4'b0100;
  localparam logic [3:0] OP_ST   = 4'b0101;
  localparam logic [3:0] OP_JMPZ = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_END  = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5,
    ST_FAULT = 3'd6
  } state_e;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [TGT_W-1:0] target_of(input logic [INSTR_W-1:0] w);
    return w[TGT_MSB:TGT_LSB];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, the instruction RAM and decode/execute.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic               start;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] iram_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               exec_done;
  logic               zero_flag;
  logic               busy;
  logic               halted;
  logic               fault;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  start, iram_data, instr_ready, exec_done, zero_flag,
    output pc_out, instr, instr_valid, busy, halted, fault, retired
  );

  modport slave (
    output start, iram_data, instr_ready, exec_done, zero_flag,
    input  pc_out, instr, instr_valid, busy, halted, fault, retired
  );

endinterface

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Combinational next-PC selection for a completing instruction, flagging END and
// any destination beyond the last legal program address.
module fetch_sequencer_next_pc_sel
  import fetch_sequencer_pkg::*;
(
  input  logic [3:0]       opcode_i,
  input  logic [TGT_W-1:0] target_i,
  input  logic             zero_flag_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic [PC_W-1:0]  next_pc_o,
  output logic             end_o,
  output logic             fault_o
);

  logic [PC_W-1:0] target_pc;

  assign target_pc = PC_W'(target_i);

  always_comb begin
    next_pc_o = pc_i + PC_W'(1);
    end_o     = 1'b0;
    case (opcode_i)
      OP_JMP:  next_pc_o = target_pc;
      OP_JMPZ: if (zero_flag_i) next_pc_o = target_pc;
      OP_END:  end_o = 1'b1;
      default: ;
    endcase
    // END halts in place, so its sequential successor is never examined.
    fault_o = !end_o && (next_pc_o > LAST_PC);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, absorbs the RAM read latency, issues each
// instruction over valid/ready, waits for completion and picks the next PC.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [PC_W-1:0]    sel_pc;
  logic               sel_end;
  logic               sel_fault;

  fetch_sequencer_next_pc_sel u_next_pc_sel (
    .opcode_i    (opcode_of(instr_q)),
    .target_i    (target_of(instr_q)),
    .zero_flag_i (bus.zero_flag),
    .pc_i        (pc_q),
    .next_pc_o   (sel_pc),
    .end_o       (sel_end),
    .fault_o     (sel_fault)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE, ST_HALT, ST_FAULT: begin
        if (bus.start) begin
          state_d   = ST_FETCH;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        instr_d = bus.iram_data;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: if (bus.instr_ready) state_d = ST_EXEC;
      ST_EXEC: begin
        if (bus.exec_done) begin
          if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
          // On END or fault the PC keeps the address of the instruction just retired.
          if (sel_end) begin
            state_d = ST_HALT;
          end else if (sel_fault) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = sel_pc;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pc_out      = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == ST_ISSUE);
  assign bus.busy        = (state_q == ST_FETCH) || (state_q == ST_LATCH) ||
                           (state_q == ST_ISSUE) || (state_q == ST_EXEC);
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: registered-read RAM model, program-level
// reference model checked every cycle, plus literal expectations at key points.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if bus();

  fetch_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [INSTR_W-1:0] ram [0:127];
  always @(posedge clk) bus.iram_data <= ram[bus.pc_out];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [3:0] op, input int tgt);
    logic [5:0] t;
    t = 6'(tgt);
    return {op, t, 10'b0};
  endfunction

  // Program-level model: running/halted/faulted, architectural PC, retired count,
  // cycles since the current fetch began and whether the instruction is executing.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
  int              m_mode  = M_IDLE;
  logic [PC_W-1:0] m_pc    = '0;
  logic [15:0]     m_ret   = '0;
  int              m_since = 0;
  bit              m_exec  = 1'b0;
  bit              model_en = 1'b0;

  always @(posedge clk) begin
    logic [INSTR_W-1:0] w;
    int nxt;
    if (rst) begin
      m_mode = M_IDLE; m_pc = '0; m_ret = '0; m_since = 0; m_exec = 1'b0;
    end else if (m_mode != M_RUN) begin
      if (bus.start) begin
        m_mode = M_RUN; m_pc = '0; m_ret = '0; m_since = 0; m_exec = 1'b0;
      end
    end else if (!m_exec) begin
      if (m_since == 2) begin
        if (bus.instr_ready) m_exec = 1'b1;
      end else begin
        m_since++;
      end
    end else if (bus.exec_done) begin
      w = ram[m_pc];
      if (m_ret != 16'hFFFF) m_ret++;
      if (w[19:16] == OP_END) begin
        m_mode = M_HALT;
      end else begin
        if (w[19:16] == OP_JMP || (w[19:16] == OP_JMPZ && bus.zero_flag))
          nxt = int'(w[15:10]);
        else
          nxt = int'(m_pc) + 1;
        if (nxt > LAST_ADDR) begin
          m_mode = M_FAULT;
        end else begin
          m_pc = PC_W'(nxt); m_since = 0; m_exec = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (model_en) begin
      ev = (m_mode == M_RUN) && !m_exec && (m_since == 2);
      chk("cyc_valid",   32'(bus.instr_valid), 32'(ev));
      chk("cyc_pc",      32'(bus.pc_out),      32'(m_pc));
      chk("cyc_busy",    32'(bus.busy),        32'(m_mode == M_RUN));
      chk("cyc_halted",  32'(bus.halted),      32'(m_mode == M_HALT));
      chk("cyc_fault",   32'(bus.fault),       32'(m_mode == M_FAULT));
      chk("cyc_retired", 32'(bus.retired),     32'(m_ret));
      if (ev) chk("cyc_instr", 32'(bus.instr), 32'(ram[m_pc]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.instr_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      errors++;
      $display("FAIL wait_valid: instr_valid never rose at %0t", $time);
    end
  endtask

  task automatic exec_cur(input bit z, input bit st);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    bus.exec_done   = 1'b1;
    bus.zero_flag   = z;
    bus.start       = st;
    tick();
    bus.exec_done   = 1'b0;
    bus.zero_flag   = 1'b0;
    bus.start       = 1'b0;
  endtask

  task automatic step(input bit z, input bit st);
    wait_valid();
    exec_cur(z, st);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},      32'(bus.pc_out),      32'd0);
    chk({tag, "_instr"},   32'(bus.instr),       32'd0);
    chk({tag, "_valid"},   32'(bus.instr_valid), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy),        32'd0);
    chk({tag, "_halted"},  32'(bus.halted),      32'd0);
    chk({tag, "_fault"},   32'(bus.fault),       32'd0);
    chk({tag, "_retired"}, 32'(bus.retired),     32'd0);
  endtask

  initial begin
    logic [INSTR_W-1:0] held;
    bus.start = 1'b0; bus.instr_ready = 1'b0; bus.exec_done = 1'b0; bus.zero_flag = 1'b0;
    for (int i = 0; i < 128; i++) ram[i] = '0;
    ram[0]  = mk(OP_ADD, 0);
    ram[1]  = mk(OP_JMP, 20);
    ram[20] = mk(OP_JMPZ, 33);
    ram[21] = mk(OP_JMP, 45);
    ram[33] = mk(OP_SUB, 0);
    ram[34] = mk(OP_ADD, 0);
    ram[35] = mk(OP_JMP, 12);
    ram[12] = mk(OP_JMP, 32);
    ram[32] = mk(OP_END, 0);
    ram[45] = mk(OP_ADD, 0);
    chk("lit_jmpz_word", 32'(ram[20]), 32'h0B8400);

    // Reset, then first fetch latency and first retirement.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_en = 1'b1;
    rst = 1'b0;
    chk_reset_vals("reset");
    start_pulse();
    chk("lat_c1_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("lat_c2_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("lat_c3_valid", 32'(bus.instr_valid), 32'd1);
    chk("lat_c3_pc",    32'(bus.pc_out),      32'd0);
    chk("lat_c3_instr", 32'(bus.instr),       32'(mk(OP_ADD, 0)));
    exec_cur(1'b0, 1'b0);
    chk("add_pc",      32'(bus.pc_out),  32'd1);
    chk("add_retired", 32'(bus.retired), 32'd1);

    // JMP, taken JMPZ, straight-line, JMP chain, END.
    step(1'b0, 1'b0); chk("jmp20_pc", 32'(bus.pc_out), 32'd20);
    step(1'b1, 1'b0); chk("jmpz_taken_pc", 32'(bus.pc_out), 32'd33);
    step(1'b0, 1'b0); chk("seq34_pc", 32'(bus.pc_out), 32'd34);
    step(1'b0, 1'b0); chk("seq35_pc", 32'(bus.pc_out), 32'd35);
    step(1'b0, 1'b0); chk("jmp12_pc", 32'(bus.pc_out), 32'd12);
    step(1'b0, 1'b0); chk("jmp32_pc", 32'(bus.pc_out), 32'd32);
    step(1'b0, 1'b0);
    chk("end_halted",  32'(bus.halted),  32'd1);
    chk("end_busy",    32'(bus.busy),    32'd0);
    chk("end_pc",      32'(bus.pc_out),  32'd32);
    chk("end_retired", 32'(bus.retired), 32'd8);
    repeat (3) tick();
    start_pulse();
    chk("restart_pc",      32'(bus.pc_out),  32'd0);
    chk("restart_halted",  32'(bus.halted),  32'd0);
    chk("restart_retired", 32'(bus.retired), 32'd0);
    chk("restart_busy",    32'(bus.busy),    32'd1);

    // Not-taken JMPZ, stalled issue with stray exec_done, fault at LAST_ADDR.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0); chk("jmpz_fall_pc", 32'(bus.pc_out), 32'd21);
    wait_valid();
    held = bus.instr;
    for (int i = 0; i < 5; i++) begin
      bus.exec_done = 1'b1;
      bus.zero_flag = 1'b1;
      tick();
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_instr", 32'(bus.instr),       32'(held));
      chk("stall_pc",    32'(bus.pc_out),      32'd21);
    end
    bus.exec_done = 1'b0;
    bus.zero_flag = 1'b0;
    exec_cur(1'b0, 1'b0); chk("jmp45_pc", 32'(bus.pc_out), 32'd45);
    step(1'b0, 1'b0);
    chk("last_fault",   32'(bus.fault),   32'd1);
    chk("last_pc",      32'(bus.pc_out),  32'd45);
    chk("last_busy",    32'(bus.busy),    32'd0);
    chk("last_retired", 32'(bus.retired), 32'd5);
    repeat (3) tick();
    chk("fault_sticky_pc",    32'(bus.pc_out),      32'd45);
    chk("fault_sticky_valid", 32'(bus.instr_valid), 32'd0);

    // Jump target past LAST_ADDR.
    ram[0] = mk(OP_JMP, 50);
    start_pulse();
    step(1'b0, 1'b0);
    chk("tgt50_fault", 32'(bus.fault),  32'd1);
    chk("tgt50_pc",    32'(bus.pc_out), 32'd0);
    ram[0] = mk(OP_ADD, 0);

    // Reset while in EXEC.
    start_pulse();
    step(1'b0, 1'b0);
    wait_valid();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("exec_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_exec");

    // Reset while in ISSUE holding a nonzero instruction.
    start_pulse();
    step(1'b0, 1'b0);
    wait_valid();
    chk("pre_rst_instr", 32'(bus.instr), 32'(mk(OP_JMP, 20)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_issue");

    // Refetch from 0; start coinciding with exec_done is ignored.
    start_pulse();
    wait_valid();
    chk("refetch_pc",    32'(bus.pc_out), 32'd0);
    chk("refetch_instr", 32'(bus.instr),  32'(mk(OP_ADD, 0)));
    exec_cur(1'b0, 1'b1);
    chk("start_ign_pc",      32'(bus.pc_out),  32'd1);
    chk("start_ign_retired", 32'(bus.retired), 32'd1);
    wait_valid();
    chk("start_ign_instr", 32'(bus.instr), 32'(mk(OP_JMP, 20)));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
